// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell (two half adders plus carry OR) walks the
// operands LSB first under an IDLE/RUN/DONE controller, registering sum and carry-out.

module hA (
    input  logic A,
    input  logic B,
    output logic Sum,
    output logic Cout
);
    assign Sum  = A ^ B;
    assign Cout = A & B;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_psum;
    logic               r_c;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_sum_out;
    logic               r_cout;

    logic               w_s0;
    logic               w_c0;
    logic               w_s;
    logic               w_c1;
    logic               w_cy;
    logic               w_last;
    logic [WIDTH-1:0]   w_psum_nxt;

    // Full-adder cell: the only adder logic in the block
    hA u_ha0 (.A(r_a[0]), .B(r_b[0]), .Sum(w_s0), .Cout(w_c0));
    hA u_ha1 (.A(w_s0),   .B(r_c),    .Sum(w_s),  .Cout(w_c1));
    assign w_cy = w_c0 | w_c1;

    assign w_last     = (r_cnt == LAST_BIT);
    assign w_psum_nxt = {w_s, r_psum[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_psum    <= '0;
            r_c       <= 1'b0;
            r_cnt     <= '0;
            r_sum_out <= '0;
            r_cout    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a    <= a_in;
                        r_b    <= b_in;
                        r_psum <= '0;
                        r_c    <= 1'b0;
                        r_cnt  <= '0;
                    end
                end
                S_RUN: begin
                    r_a    <= r_a >> 1;
                    r_b    <= r_b >> 1;
                    r_psum <= w_psum_nxt;
                    r_c    <= w_cy;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    // Final bit: publish the completed result on the same edge
                    if (w_last) begin
                        r_sum_out <= w_psum_nxt;
                        r_cout    <= w_cy;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum_out = r_sum_out;
    assign cout    = r_cout;

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal values are 2 to 32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition, sampled only in IDLE.
REQ-005 The block SHALL have port a_in, input, WIDTH bits: operand A, captured when start is accepted.
REQ-006 The block SHALL have port b_in, input, WIDTH bits: operand B, captured when start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-008 The block SHALL have port done, output, 1 bit: a one-cycle pulse marking a valid result.
REQ-009 The block SHALL have port sum_out, output, WIDTH bits: the registered sum of the last completed operation.
REQ-010 The block SHALL have port cout, output, 1 bit: the registered carry-out of the last completed operation.

Function
REQ-011 The block SHALL add bit-serially, one bit per cycle, LSB first, through a single full-adder cell.
REQ-012 The full-adder cell SHALL be built from two hA instances (ports A, B, Sum, Cout) plus an OR of their carries; no other adder logic is permitted.
REQ-013 The block SHALL implement a state machine with exactly three states: IDLE, RUN and DONE.
REQ-014 In IDLE, if start=1 at a clock edge, the block SHALL load a_in and b_in into shift registers, clear the carry flop and the bit counter, and move to RUN.
REQ-015 In IDLE, if start=0, the block SHALL remain in IDLE.
REQ-016 On each RUN cycle, the block SHALL:
- compute s = a[0]^b[0]^c;
- shift s into the MSB of the partial-sum register, which shifts right;
- shift both operand registers right;
- update c with the cell carry;
- increment the bit counter.
REQ-017 RUN SHALL last exactly WIDTH cycles, and the transition to DONE SHALL occur on the edge that processes bit WIDTH-1.
REQ-018 On that same edge, sum_out SHALL load the completed sum and cout SHALL load the final carry.
REQ-019 In DONE, done SHALL be 1 for exactly one cycle, and the next edge SHALL return the block to IDLE unconditionally.
REQ-020 Latency: if start is accepted at edge k, done SHALL be high in the cycle following edge k+WIDTH.
REQ-021 Throughput: with start held high, accepted operations SHALL repeat every WIDTH+2 cycles.
REQ-022 start, a_in and b_in SHALL be ignored while busy=1, and input changes during RUN SHALL NOT affect the result.
REQ-023 sum_out and cout SHALL hold their values until the next completion; a new start SHALL NOT clear them.
REQ-024 The result SHALL equal (a_in + b_in) mod 2^WIDTH, with cout equal to bit WIDTH of the true sum.
REQ-025 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap within an operation.

Reset
REQ-026 While rst=1 at a clock edge, the block SHALL:
- set the state to IDLE;
- set busy=0, done=0, sum_out=0 and cout=0;
- clear the operand, partial-sum, carry and counter registers.
REQ-027 rst SHALL take priority over start in the same cycle.
REQ-028 rst asserted during RUN or DONE SHALL abort the operation, with no done pulse produced for that operation.
REQ-029 After rst is released, the first start SHALL be accepted on the first edge with rst=0 and start=1.

Verification (WIDTH=8)
REQ-030 Reset check: rst=1 for 2 cycles with random inputs -> busy=0, done=0, sum_out=0x00 and cout=0 throughout.
REQ-031 Basic add: a_in=0x5A, b_in=0x33, start pulsed 1 cycle at edge k -> done high in the cycle after edge k+8, sum_out=0x8D, cout=0, busy high for 9 cycles.
REQ-032 Carry ripple: a_in=0xFF, b_in=0x01 -> sum_out=0x00 and cout=1, with both values held after done falls.
REQ-033 Back-to-back: start held high with a_in=0x80, b_in=0x80 -> done pulses every 10 cycles, each giving sum_out=0x00 and cout=1, with busy low exactly 1 cycle between operations.
REQ-034 Ignored start: a_in=0x01, b_in=0x02 started, then a_in=0xF0, b_in=0x0F with start=1 in RUN cycle 3 -> exactly one done, with sum_out=0x03 and cout=0.
REQ-035 Mid-run reset: a_in=0x5A, b_in=0x33 started, then rst=1 in RUN cycle 4 -> IDLE on the next edge, no done pulse, sum_out=0x00; a following start with a_in=0x10, b_in=0x20 -> sum_out=0x30.
